ssd_mux: RTL and testbench
==========================

SSD_MUX -- requirements
Module: ssd_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter DIV_BITS, default 8, prescaler width; one digit slot = 2^DIV_BITS clk cycles (legal 4..24).
REQ-003 SHALL have port clk, input, 1, sole clock; all flops on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port activate, input, 1, display enable.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS, hex digits; digit 0 = value[4*NUM_DIGITS-1 -: 4] (most significant).
REQ-007 SHALL have port dp_in, input, NUM_DIGITS, decimal point request; dp_in[i] for digit i.
REQ-008 SHALL have port brightness, input, 4, PWM duty in sixteenths.
REQ-009 SHALL have port an, output, NUM_DIGITS, active-low anode select; an[i] drives digit i.
REQ-010 SHALL have port segments, output, 7, active-low {g,f,e,d,c,b,a}.
REQ-011 SHALL have port dp, output, 1, active-low decimal point.
REQ-012 SHALL have port frame_done, output, 1, one-cycle pulse at end of each full scan.

Function
REQ-013 SHALL use no derived clocks; a DIV_BITS-bit free-running prescaler generates a one-cycle tick when it equals all ones.
REQ-014 SHALL implement two states: IDLE (activate low) and SCAN (activate high).
REQ-015 IDLE SHALL hold an all ones, segments 7'h7F, dp 1, digit index 0, prescaler 0.
REQ-016 On the edge where activate is first seen high in IDLE, SHALL enter SCAN, load the shadow register from value and dp_in, and set digit index 0 and prescaler 0.
REQ-017 In SCAN, digit index SHALL advance on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-018 On the wrap tick, SHALL reload the shadow from value/dp_in and pulse frame_done for exactly one cycle; value changes mid-frame SHALL NOT appear until the next frame.
REQ-019 Displayed nibble and dp SHALL come only from the shadow, never directly from value.
REQ-020 Hex font (active-low) SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 an[index] SHALL be low only while prescaler[DIV_BITS-1 -: 4] < brightness; brightness 0 SHALL keep all anodes high. Segments SHALL still show the selected digit.
REQ-022 an, segments and dp SHALL be registered, one clk after the index/prescaler state that selects them.
REQ-023 When activate falls, SHALL return to IDLE on that edge, with outputs blank on the following cycle; no frame_done SHALL be emitted.
REQ-024 Activate toggling within one slot SHALL restart scanning from digit 0 with a fresh shadow load.

Reset
REQ-025 Reset SHALL force IDLE, prescaler 0, index 0, shadow 0, an all ones, segments 7'h7F, dp 1, frame_done 0.
REQ-026 Reset asserted mid-frame SHALL blank outputs immediately (asynchronously), with no frame_done.
REQ-027 After reset deassertion with activate high, SHALL follow REQ-016 on the first clock edge.

Configuration
REQ-028 SHALL support macro SSD_LZ_BLANK_EN.
REQ-029 With SSD_LZ_BLANK_EN defined, shadow digits equal to 0 that precede the first nonzero digit SHALL keep their anode high; digit NUM_DIGITS-1 is always shown; dp_in[i]=1 stops suppression at digit i.
REQ-030 Without SSD_LZ_BLANK_EN, all digits SHALL be shown, including leading zeros.

Verification (NUM_DIGITS=4, DIV_BITS=4)
REQ-031 Reset; activate=1, value=16'h1A3F, brightness=15, dp_in=0 -> an cycles 1110,1101,1011,0111 every 16 clk; segments 1111001,0001000,0110000,0001110; frame_done high once per 64 clk.
REQ-032 Change value 16'h1A3F->16'h0000 during digit 1 -> digits 2,3 still show 3,F; 0 shown only after the frame_done.
REQ-033 brightness=4 -> selected anode low 4 of 16 cycles per slot; brightness=0 -> an stays 1111 while segments still change.
REQ-034 value=16'h0045 with SSD_LZ_BLANK_EN -> digits 0,1 anodes never low; dp_in=4'b0100 -> digit 1 also blank and digit 2 dp=0. Without the macro, all four anodes are active.
REQ-035 activate drops mid-slot, or reset asserts mid-frame -> an=1111, segments=7'h7F, no frame_done; re-activate -> scan restarts at digit 0.

Source files
------------

// File: rtl/ssd_mux.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// ssd_mux -- time-multiplexed driver for a common-anode seven-segment display
//
// Scans NUM_DIGITS hex digits one at a time. A DIV_BITS-wide free-running
// prescaler sets the slot length: each digit is selected for 2^DIV_BITS clk
// cycles. The anode of the selected digit is PWM-dimmed by `brightness`
// (sixteenths of a slot). The digits are shown from a shadow copy of
// `value`/`dp_in`. The copy is taken when scanning starts and again at the
// end of every full frame, so a frame never shows a mix of old and new data.
//
// Parameters
//   NUM_DIGITS  number of digits, legal 2..8 (default 4)
//   DIV_BITS    prescaler width, legal 4..24 (default 8)
//
// Ports
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   activate    display enable; low = IDLE (blank), high = SCAN
//   value       4*NUM_DIGITS hex digits, digit 0 is the most significant nibble
//   dp_in       decimal point request, dp_in[i] belongs to digit i
//   brightness  anode duty in sixteenths of a slot (0 = dark)
//   an          active-low anode selects, an[i] drives digit i
//   segments    active-low {g,f,e,d,c,b,a}
//   dp          active-low decimal point
//   frame_done  one-cycle pulse after the last slot of every full scan
//   state_dbg   FSM state for observation (0 = IDLE, 1 = SCAN)
//
// Handshake: there is no valid/ready pair here. `activate` is a level.
// `value`/`dp_in` are sampled only on the shadow-load edges, which are
// entry into SCAN and the frame wrap. Between those edges the inputs may
// change freely without any effect on the display.
//
// Build option
//   SSD_LZ_BLANK_EN  when defined, zero digits ahead of the first nonzero
//                    digit are blanked. Blanking means their anode stays high.
//                    The last digit is always shown. A requested decimal point
//                    ends the blanking at its own digit.
// ---------------------------------------------------------------------------
module ssd_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    activate,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    state_dbg
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t                  state;
  logic [DIV_BITS-1:0]     prescaler;
  logic [IDX_W-1:0]        index;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  // Derived, purely combinational views of the current state
  logic                    tick;
  logic [3:0]              digit_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   shown;
  logic [3:0]              duty_phase;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   an_next;
`ifdef SSD_LZ_BLANK_EN
  logic                    suppress;
`endif

  assign state_dbg = (state == SCAN);

  // Slot boundary: the prescaler is about to roll over
  assign tick = &prescaler;

  // The top four prescaler bits act as a 0..15 ramp across the slot. The
  // anode is lit while the ramp is below the requested duty, so brightness 0
  // never lights the anode.
  assign duty_phase = prescaler[DIV_BITS-1 -: 4];
  assign lit        = (duty_phase < brightness);

  // Active-low hex font, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_font(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Split the shadow into per-digit nibbles. Digit 0 is the MS nibble.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_nib[i] = shadow_val[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  // Which digits are allowed to light their anode
  always_comb begin
    shown = '1;
`ifdef SSD_LZ_BLANK_EN
    // Walk from the most significant digit. Suppression holds until the
    // first nonzero digit, the first digit with a decimal point, or the
    // last digit, whichever comes first.
    suppress = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i == NUM_DIGITS - 1) || (digit_nib[i] != 4'd0) || shadow_dp[i]) begin
        suppress = 1'b0;
      end
      shown[i] = !suppress;
    end
`endif
  end

  // Anode pattern for the current index/prescaler. This is registered below.
  always_comb begin
    an_next = '1;
    if (lit && shown[index]) begin
      an_next[index] = 1'b0;
    end
  end

  // FSM, scan counters, shadow register and registered display outputs.
  // The outputs are recomputed every edge from the pre-edge state. Any edge
  // that does not see SCAN with activate high writes the blank pattern, so
  // the display goes dark on the edge where activate is seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      index      <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      an         <= '1;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      an         <= '1;
      segments   <= 7'h7F;
      dp         <= 1'b1;

      case (state)
        IDLE: begin
          prescaler <= '0;
          index     <= '0;
          if (activate) begin
            state      <= SCAN;
            shadow_val <= value;
            shadow_dp  <= dp_in;
          end
        end

        SCAN: begin
          if (!activate) begin
            // Drop straight back to IDLE and emit no frame_done for the
            // frame that was cut short
            state     <= IDLE;
            prescaler <= '0;
            index     <= '0;
          end else begin
            an        <= an_next;
            segments  <= hex_font(digit_nib[index]);
            dp        <= ~shadow_dp[index];
            prescaler <= prescaler + 1'b1;
            if (tick) begin
              if (index == LAST_IDX) begin
                // Frame boundary: take a fresh snapshot for the next frame
                index      <= '0;
                shadow_val <= value;
                shadow_dp  <= dp_in;
                frame_done <= 1'b1;
              end else begin
                index <= index + 1'b1;
              end
            end
          end
        end

        default: begin
          state     <= IDLE;
          prescaler <= '0;
          index     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssd_mux.sv
`timescale 1ns / 1ps
// ---------------------------------------------------------------------------
// tb_ssd_mux -- directed bench for ssd_mux (NUM_DIGITS=4, DIV_BITS=4)
//
// The bench drives inputs at the falling edge and samples the outputs at the
// falling edge. k counts the rising edges since the entry edge into SCAN, so
// with 16-cycle slots the sample after edge k shows
// digit ((k-1)/16)%4 at prescaler phase (k-1)%16. frame_done is high after
// every 64th edge.
// ---------------------------------------------------------------------------
module tb_ssd_mux;

  localparam int ND    = 4;
  localparam int DB    = 4;
  localparam int SLOT  = 16;
  localparam int FRAME = 64;

  // Active-low font, {g,f,e,d,c,b,a}, indexed by nibble
  localparam logic [6:0] FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // {an, segments, dp, frame_done} with everything dark
  localparam logic [12:0] BLANK = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        activate   = 1'b0;
  logic [15:0] value      = '0;
  logic [3:0]  dp_in      = '0;
  logic [3:0]  brightness = '0;
  logic [3:0]  an;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_done;
  logic        state_dbg;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] exp_q[$];

  ssd_mux #(
    .NUM_DIGITS(ND),
    .DIV_BITS  (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .value     (value),
    .dp_in     (dp_in),
    .brightness(brightness),
    .an        (an),
    .segments  (segments),
    .dp        (dp),
    .frame_done(frame_done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  // Expected {an, segments, dp, frame_done} after edge k of a scan whose
  // frame shadow holds val/dpv
  function automatic logic [12:0] exp_word(input int k, input logic [15:0] val,
                                           input logic [3:0] dpv, input logic [3:0] bright);
    int         d;
    int         p;
    int         first;
    logic [3:0] nib;
    logic [3:0] an_v;
    logic       fd;
    d     = ((k - 1) / SLOT) % ND;
    p     = (k - 1) % SLOT;
    nib   = val[15-4*d -: 4];
    first = 0;
`ifdef SSD_LZ_BLANK_EN
    // first digit allowed to light: first nonzero or dp-marked digit, else the last
    first = ND - 1;
    for (int i = ND - 1; i >= 0; i--) begin
      if (val[15-4*i -: 4] != 4'd0 || dpv[i]) first = i;
    end
`endif
    an_v = 4'hF;
    if (p < int'(bright) && d >= first) an_v[d] = 1'b0;
    fd = ((k % FRAME) == 0);
    return {an_v, FONT[nib], ~dpv[d], fd};
  endfunction

  // ---------------- driver tasks ----------------
  // Call at a falling edge with the DUT in IDLE. The next rising edge is the entry edge.
  task automatic start_scan(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] bright);
    value      = v;
    dp_in      = dpv;
    brightness = bright;
    activate   = 1'b1;
    @(negedge clk);
    check("entry_blank", {an, segments, dp, frame_done}, BLANK);
    check("entry_state", state_dbg, 1'b1);
  endtask

  // Check edges 1..kmax after entry. Frame 0 shows v0 and later frames show
  // v1. value is switched to v1 after sample change_k.
  task automatic scan_check(input string tag, input int kmax, input logic [15:0] v0,
                            input logic [15:0] v1, input int change_k,
                            input logic [3:0] dpv, input logic [3:0] bright);
    for (int k = 1; k <= kmax; k++) begin
      exp_q.push_back(exp_word(k, (k <= FRAME) ? v0 : v1, dpv, bright));
      @(negedge clk);
      check($sformatf("%s k=%0d", tag, k), {an, segments, dp, frame_done}, exp_q.pop_front());
      if (k == change_k) value = v1;
    end
  endtask

  // Drop activate at a falling edge and confirm IDLE and a dark display
  task automatic stop_scan(input string tag);
    activate = 1'b0;
    @(negedge clk);
    check($sformatf("%s_state", tag), state_dbg, 1'b0);
    check($sformatf("%s_fd", tag), frame_done, 1'b0);
    @(negedge clk);
    check($sformatf("%s_blank", tag), {an, segments, dp, frame_done}, BLANK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("reset_out", {an, segments, dp, frame_done}, BLANK);
    check("reset_state", state_dbg, 1'b0);

    // Release reset with activate already high: the first edge enters SCAN.
    // value goes to 0000 during digit 1. Digits 2 and 3 of that frame still
    // show 3 and F, and zeros appear only after the frame_done.
    reset = 1'b0;
    start_scan(16'h1A3F, 4'b0000, 4'd15);
    scan_check("basic", 136, 16'h1A3F, 16'h0000, 20, 4'b0000, 4'd15);

    // Dimming: 4/16 duty, then fully dark anodes with segments still cycling
    stop_scan("stop1");
    start_scan(16'h1A3F, 4'b0000, 4'd4);
    scan_check("bright4", 64, 16'h1A3F, 16'h1A3F, 0, 4'b0000, 4'd4);
    stop_scan("stop2");
    start_scan(16'h1A3F, 4'b0000, 4'd0);
    scan_check("bright0", 64, 16'h1A3F, 16'h1A3F, 0, 4'b0000, 4'd0);

    // Leading zeros, then with a decimal point on digit 2
    stop_scan("stop3");
    start_scan(16'h0045, 4'b0000, 4'd15);
    scan_check("lz", 64, 16'h0045, 16'h0045, 0, 4'b0000, 4'd15);
    stop_scan("stop4");
    start_scan(16'h0045, 4'b0100, 4'd15);
    scan_check("lz_dp", 64, 16'h0045, 16'h0045, 0, 4'b0100, 4'd15);

    // activate drops mid-slot (digit 1), then scanning restarts at digit 0
    stop_scan("stop5");
    start_scan(16'h1A3F, 4'b0000, 4'd15);
    scan_check("pre_drop", 25, 16'h1A3F, 16'h1A3F, 0, 4'b0000, 4'd15);
    stop_scan("drop");
    start_scan(16'h1A3F, 4'b0000, 4'd15);
    scan_check("after_drop", 20, 16'h1A3F, 16'h1A3F, 0, 4'b0000, 4'd15);

    // One-cycle toggle of activate inside a slot: a fresh shadow load and digit 0
    activate = 1'b0;
    value    = 16'h7B2C;
    @(negedge clk);
    start_scan(16'h7B2C, 4'b0000, 4'd15);
    scan_check("toggle", 40, 16'h7B2C, 16'h7B2C, 0, 4'b0000, 4'd15);

    // Reset mid-frame: blank before the next clock edge, and no frame_done
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_out", {an, segments, dp, frame_done}, BLANK);
    check("rst_async_state", state_dbg, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_hold_out", {an, segments, dp, frame_done}, BLANK);
    reset = 1'b0;
    start_scan(16'hE9D6, 4'b0001, 4'd15);
    scan_check("after_rst", 70, 16'hE9D6, 16'hE9D6, 0, 4'b0001, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
